interrupt_gateway: RTL and testbench

INTERRUPT_GATEWAY -- requirements
Module: interrupt_gateway

---
 rtl/interrupt_pkg.sv | 14 +
 rtl/interrupt_gateway_if.sv | 29 ++
 rtl/gateway_cell.sv | 70 +++++++
 rtl/interrupt_gateway.sv | 71 +++++++
 tb/tb_interrupt_gateway.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/interrupt_pkg.sv
// Shared types and constants for the interrupt gateway.
//   src_state_e  : per-source lifecycle IDLE -> PENDING -> SERVICE
//   SYNC_STAGES  : depth of the input synchronizer ahead of edge detection
package interrupt_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_SERVICE = 2'd2
  } src_state_e;

endpackage

// File: rtl/interrupt_gateway_if.sv
// Claim/complete handshake between the gateway, the priority tree and the hart.
//   i_sel_index/i_sel_valid : winner reported by the priority search tree
//   i_claim                 : one-cycle claim strobe from the hart
//   o_claim_index/valid     : registered claim response
//   i_complete/_index       : one-cycle completion strobe and its source
// master = hart/tree side, slave = gateway side.
interface interrupt_gateway_if #(
  parameter int N = 4
);
  localparam int M = $clog2(N);

  logic [M-1:0] i_sel_index;
  logic         i_sel_valid;
  logic         i_claim;
  logic [M-1:0] o_claim_index;
  logic         o_claim_valid;
  logic         i_complete;
  logic [M-1:0] i_complete_index;

  modport master (
    output i_sel_index, i_sel_valid, i_claim, i_complete, i_complete_index,
    input  o_claim_index, o_claim_valid
  );

  modport slave (
    input  i_sel_index, i_sel_valid, i_claim, i_complete, i_complete_index,
    output o_claim_index, o_claim_valid
  );
endinterface

// File: rtl/gateway_cell.sv
// One interrupt source: synchronizer, edge detect, lifecycle state, again flag.
//   i_clk, i_rst_n  : clock, async active-low reset
//   i_source        : raw line, asynchronous to i_clk
//   i_edge          : 1 = rising-edge mode, 0 = level-high mode
//   i_claim_hit     : claim granted to this source this cycle
//   i_complete_hit  : completion addressed to this source this cycle
//   o_pending       : state == PENDING
//   o_in_service    : state == SERVICE
module gateway_cell
  import interrupt_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_source,
  input  logic i_edge,
  input  logic i_claim_hit,
  input  logic i_complete_hit,
  output logic o_pending,
  output logic o_in_service
);

  // [SYNC_STAGES-1] is the synchronized line, [SYNC_STAGES] its delayed copy.
  logic [SYNC_STAGES:0] sync_q;
  logic                 rise_q;
  logic                 again_q;
  src_state_e           state_q;

  logic sync_lvl;
  assign sync_lvl = sync_q[SYNC_STAGES-1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q  <= '0;
      rise_q  <= 1'b0;
      again_q <= 1'b0;
      state_q <= ST_IDLE;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-1:0], i_source};
      // Registered edge pulse: edge mode sees one more cycle of latency
      // than level mode.
      rise_q <= sync_lvl & ~sync_q[SYNC_STAGES];

      case (state_q)
        ST_IDLE: begin
          if (i_edge ? rise_q : sync_lvl) state_q <= ST_PENDING;
        end
        ST_PENDING: begin
          if (i_claim_hit)       state_q <= ST_SERVICE;
          if (i_edge && rise_q)  again_q <= 1'b1;
        end
        ST_SERVICE: begin
          if (i_complete_hit) begin
            // An edge arriving on the completion cycle counts as "again" too.
            // Level mode goes via IDLE and re-pends next cycle if still high.
            if (i_edge && (again_q || rise_q)) state_q <= ST_PENDING;
            else                               state_q <= ST_IDLE;
            again_q <= 1'b0;
          end else if (i_edge && rise_q) begin
            again_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_pending    = (state_q == ST_PENDING);
  assign o_in_service = (state_q == ST_SERVICE);

endmodule

// File: rtl/interrupt_gateway.sv
// Interrupt gateway: N per-source cells plus the claim response register.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_sources      : raw interrupt lines (asynchronous)
//   i_edge         : per-source mode, 1 = rising edge, 0 = level high
//   o_pending      : pending vector to the priority search tree
//   o_in_service   : sources currently being serviced
//   bus            : claim/complete handshake (slave side)
module interrupt_gateway
  import interrupt_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [N-1:0] i_sources,
  input  logic [N-1:0] i_edge,
  output logic [N-1:0] o_pending,
  output logic [N-1:0] o_in_service,
  interrupt_gateway_if.slave bus
);

  localparam int M = $clog2(N);

  logic [N-1:0] sel_hit;
  logic [N-1:0] cmp_hit;
  logic [N-1:0] claim_hit;
  logic [N-1:0] complete_hit;
  logic         claim_ok;
  logic         claim_valid_q;
  logic [M-1:0] claim_index_q;

  // One-hot decode; indices >= N match no cell and are therefore ignored.
  genvar k;
  generate
    for (k = 0; k < N; k++) begin : g_cell
      assign sel_hit[k] = (bus.i_sel_index == M'(k));
      assign cmp_hit[k] = (bus.i_complete_index == M'(k));

      gateway_cell u_cell (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_source       (i_sources[k]),
        .i_edge         (i_edge[k]),
        .i_claim_hit    (claim_hit[k]),
        .i_complete_hit (complete_hit[k]),
        .o_pending      (o_pending[k]),
        .o_in_service   (o_in_service[k])
      );
    end
  endgenerate

  // Both judged on pre-edge state, so a claim and a complete in the same
  // cycle act independently.
  assign claim_ok     = bus.i_claim & bus.i_sel_valid & |(sel_hit & o_pending);
  assign claim_hit    = {N{claim_ok}} & sel_hit;
  assign complete_hit = {N{bus.i_complete}} & cmp_hit & o_in_service;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      claim_valid_q <= 1'b0;
      claim_index_q <= '0;
    end else begin
      claim_valid_q <= claim_ok;
      claim_index_q <= claim_ok ? bus.i_sel_index : '0;
    end
  end

  assign bus.o_claim_valid = claim_valid_q;
  assign bus.o_claim_index = claim_index_q;

endmodule

// File: tb/tb_interrupt_gateway.sv
// Directed bench for interrupt_gateway (N=4). Inputs change and outputs are
// sampled on the falling edge.
module tb_interrupt_gateway;

  localparam int N = 4;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] sources;
  logic [N-1:0] edge_mode;
  logic [N-1:0] pending;
  logic [N-1:0] in_service;

  int checks;
  int failures;

  interrupt_gateway_if #(.N(N)) bus ();

  interrupt_gateway #(.N(N)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_sources    (sources),
    .i_edge       (edge_mode),
    .o_pending    (pending),
    .o_in_service (in_service),
    .bus          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic claim(input logic valid, input logic [1:0] sel);
    bus.i_claim = 1'b1; bus.i_sel_valid = valid; bus.i_sel_index = sel;
    tick(1);
    bus.i_claim = 1'b0; bus.i_sel_valid = 1'b0; bus.i_sel_index = 2'd0;
  endtask

  task automatic complete(input logic [1:0] idx);
    bus.i_complete = 1'b1; bus.i_complete_index = idx;
    tick(1);
    bus.i_complete = 1'b0; bus.i_complete_index = 2'd0;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; sources = '0; edge_mode = '0;
    bus.i_claim = 1'b0; bus.i_sel_valid = 1'b0; bus.i_sel_index = 2'd0;
    bus.i_complete = 1'b0; bus.i_complete_index = 2'd0;
    tick(2);
    chk("rst_pending", 32'(pending), 32'h0);
    chk("rst_in_service", 32'(in_service), 32'h0);
    chk("rst_claim_valid", 32'(bus.o_claim_valid), 32'h0);
    chk("rst_claim_index", 32'(bus.o_claim_index), 32'h0);
    rst_n = 1'b1;
    tick(1);

    // Level source 2: pending after the third edge.
    sources = 4'b0100;
    tick(2);
    chk("lvl_latency_early", 32'(pending), 32'h0);
    tick(1);
    chk("lvl_pending", 32'(pending), 32'h4);
    claim(1'b1, 2'd2);
    chk("lvl_claim_valid", 32'(bus.o_claim_valid), 32'h1);
    chk("lvl_claim_index", 32'(bus.o_claim_index), 32'h2);
    chk("lvl_in_service", 32'(in_service), 32'h4);
    chk("lvl_pending_cleared", 32'(pending), 32'h0);
    tick(1);
    chk("claim_pulse_valid", 32'(bus.o_claim_valid), 32'h0);
    chk("claim_pulse_index", 32'(bus.o_claim_index), 32'h0);
    // Complete with line still high: IDLE for one cycle, then PENDING again.
    complete(2'd2);
    chk("lvl_cmp_idle", 32'({pending, in_service}), 32'h00);
    tick(1);
    chk("lvl_repend", 32'(pending), 32'h4);
    // Line drop does not clear PENDING.
    sources = 4'b0000;
    tick(3);
    chk("lvl_sticky_pending", 32'(pending), 32'h4);
    claim(1'b1, 2'd2);
    complete(2'd2);
    tick(1);
    chk("lvl_drained", 32'({pending, in_service}), 32'h00);

    // Stale claims and a complete to a non-SERVICE source.
    sources = 4'b0001;
    tick(3);
    chk("src0_pending", 32'(pending), 32'h1);
    claim(1'b0, 2'd0);
    chk("stale_nosel_valid", 32'(bus.o_claim_valid), 32'h0);
    chk("stale_nosel_index", 32'(bus.o_claim_index), 32'h0);
    chk("stale_nosel_state", 32'({pending, in_service}), 32'h10);
    claim(1'b1, 2'd3);
    chk("stale_idle_valid", 32'(bus.o_claim_valid), 32'h0);
    chk("stale_idle_state", 32'({pending, in_service}), 32'h10);
    complete(2'd0);
    chk("cmp_not_service", 32'({pending, in_service}), 32'h10);

    // Simultaneous claim of 3 and complete of 0.
    claim(1'b1, 2'd0);
    chk("src0_claim_index", 32'(bus.o_claim_index), 32'h0);
    chk("src0_in_service", 32'(in_service), 32'h1);
    sources = 4'b1001;
    tick(3);
    chk("src3_pending", 32'(pending), 32'h8);
    bus.i_complete = 1'b1; bus.i_complete_index = 2'd0;
    claim(1'b1, 2'd3);
    bus.i_complete = 1'b0;
    chk("simul_in_service", 32'(in_service), 32'h8);
    chk("simul_claim_valid", 32'(bus.o_claim_valid), 32'h1);
    chk("simul_claim_index", 32'(bus.o_claim_index), 32'h3);
    chk("simul_pending", 32'(pending), 32'h0);
    tick(1);
    chk("simul_src0_repend", 32'(pending), 32'h1);
    sources = 4'b0000;
    tick(3);
    complete(2'd3);
    claim(1'b1, 2'd0);
    complete(2'd0);
    tick(1);
    chk("simul_drained", 32'({pending, in_service}), 32'h00);

    // Edge mode on source 1 with re-arm.
    edge_mode = 4'b0010;
    sources = 4'b0010;
    tick(1);
    sources = 4'b0000;
    tick(2);
    chk("edge_latency_early", 32'(pending), 32'h0);
    tick(1);
    chk("edge_pending", 32'(pending), 32'h2);
    claim(1'b1, 2'd1);
    chk("edge_in_service", 32'(in_service), 32'h2);
    sources = 4'b0010;
    tick(1);
    sources = 4'b0000;
    tick(4);
    chk("edge_again_held", 32'({pending, in_service}), 32'h02);
    complete(2'd1);
    chk("edge_rearm", 32'({pending, in_service}), 32'h20);
    claim(1'b1, 2'd1);
    chk("edge_claim2", 32'(in_service), 32'h2);
    complete(2'd1);
    tick(2);
    chk("edge_no_rearm", 32'({pending, in_service}), 32'h00);

    // Asynchronous reset in the middle of service.
    edge_mode = 4'b0000;
    sources = 4'b0100;
    tick(3);
    claim(1'b1, 2'd2);
    chk("pre_rst_in_service", 32'(in_service), 32'h4);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_outputs",
        32'({pending, in_service, bus.o_claim_valid, bus.o_claim_index}), 32'h0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    chk("post_rst_early", 32'({pending, in_service}), 32'h00);
    tick(1);
    chk("post_rst_pending", 32'({pending, in_service}), 32'h40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
